pollable_memory_arbiter: RTL and testbench

Two-port arbiter that shares one single-port pollable RAM between the parallel-bus host slave (port 0) and an internal requester such as a waveform playback sequencer (port 1). Each port issues a single read or write word access with a req/ack handshake. The arbiter serialises the accesses, drives the RAM port from registers and returns read data. It sits between the bus slave state machine and the RAM_inferred instance, all in the clock50 domain.

---
 rtl/pollable_memory_pkg.sv | 13 +
 rtl/round_robin_pick2.sv | 17 +
 rtl/pollable_memory_arbiter.sv | 107 ++++++++++
 tb/tb_pollable_memory_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pollable_memory_pkg.sv
// Shared definitions for the pollable RAM arbiter: FSM encoding and port indices.
package pollable_memory_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   localparam logic PORT_HOST     = 1'b0;
   localparam logic PORT_INTERNAL = 1'b1;

endpackage

// File: rtl/round_robin_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the port
// opposite last_grant. Purely combinational.
module round_robin_pick2 (
   input  logic [1:0] eligible,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_index
);

   always_comb begin
      grant_valid = |eligible;
      grant_index = eligible[1];
      if (&eligible)
         grant_index = ~last_grant;
   end

endmodule

// File: rtl/pollable_memory_arbiter.sv
// Serialises single-word accesses from two req/ack ports onto one registered RAM port.
// Latency: request sampled in IDLE -> ack 3 cycles later; one access per 3 clocks.
module pollable_memory_arbiter
   import pollable_memory_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clock50,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  ack0,
   output logic [DATA_WIDTH-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  busy
);

   state_t state;
   logic   grant;
   logic   last_grant;
   logic   wr_op;
   logic   grant_valid;
   logic   grant_index;
   logic [1:0] eligible;

   // A port whose ack is still high is finishing its handshake and must not re-win.
   assign eligible = {req1 & ~ack1, req0 & ~ack0};

   round_robin_pick2 u_pick (
      .eligible    (eligible),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_index (grant_index)
   );

   always_ff @(posedge clock50) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= PORT_HOST;
         last_grant <= PORT_INTERNAL;
         wr_op      <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         ram_addr   <= '0;
         ram_din    <= '0;
         ram_we     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  grant      <= grant_index;
                  last_grant <= grant_index;
                  if (grant_index == PORT_INTERNAL) begin
                     ram_addr <= addr1;
                     ram_din  <= wdata1;
                     ram_we   <= we1;
                     wr_op    <= we1;
                  end else begin
                     ram_addr <= addr0;
                     ram_din  <= wdata0;
                     ram_we   <= we0;
                     wr_op    <= we0;
                  end
                  busy  <= 1'b1;
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               ram_we <= 1'b0;
               state  <= COMPLETE;
            end
            COMPLETE: begin
               if (grant == PORT_INTERNAL) begin
                  ack1 <= 1'b1;
                  if (!wr_op)
                     rdata1 <= ram_dout;
               end else begin
                  ack0 <= 1'b1;
                  if (!wr_op)
                     rdata0 <= ram_dout;
               end
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pollable_memory_arbiter.sv
// Bench for pollable_memory_arbiter: vector table, corner-case sequences, and a
// randomized two-requester run against a transaction-timing reference model.
module tb_pollable_memory_arbiter;

   localparam int AW = 8;
   localparam int DW = 16;

   logic clock50 = 1'b0;
   always #5 clock50 = ~clock50;

   logic          reset;
   logic [1:0]    req, we, ack;
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wdata [2];
   logic [DW-1:0] rdata [2];
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din, ram_dout;
   logic          ram_we, busy;
   logic          ram_clr;
   logic [DW-1:0] ram [256];

   pollable_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock50 (clock50),  .reset   (reset),
      .req0    (req[0]),   .we0     (we[0]),   .addr0 (addr[0]), .wdata0 (wdata[0]),
      .ack0    (ack[0]),   .rdata0  (rdata[0]),
      .req1    (req[1]),   .we1     (we[1]),   .addr1 (addr[1]), .wdata1 (wdata[1]),
      .ack1    (ack[1]),   .rdata1  (rdata[1]),
      .ram_addr(ram_addr), .ram_din (ram_din), .ram_we (ram_we), .ram_dout (ram_dout),
      .busy    (busy)
   );

   // RAM_inferred stand-in: registered read, not reset by the arbiter.
   always_ff @(posedge clock50) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) ram[i] <= '0;
      end else if (ram_we) begin
         ram[ram_addr] <= ram_din;
      end
      ram_dout <= ram[ram_addr];
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      req   = 2'b00;
      repeat (2) @(negedge clock50);
      reset = 1'b0;
   endtask

   // Single access on one port; checks 3-cycle latency, silent other port, 1-cycle ack.
   task automatic do_op(input bit p, input bit w, input logic [7:0] a,
                        input logic [15:0] d, input string name);
      int n;
      bit other;
      req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
      n = 0; other = 1'b0;
      do begin
         @(negedge clock50);
         n++;
         if (ack[!p]) other = 1'b1;
      end while (!ack[p] && n < 20);
      check({name, "_lat"}, n, 3);
      check({name, "_other_ack"}, other, 0);
      req[p] = 1'b0;
      @(negedge clock50);
      check({name, "_ack_width"}, ack[p], 0);
   endtask

   typedef struct {
      bit          port;
      bit          we;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   // reference-model state for the randomized phase
   logic [DW-1:0] mem_ref [256];
   logic [DW-1:0] erd [2];
   bit            pv, pport, pread, last;
   int            pdone;
   logic [DW-1:0] prd;
   int            st [2];

   initial begin
      int n, n_ev, lowrun, spurious, t0, t1;
      bit seen, prev_busy;
      bit [1:0] drop;
      bit ev_port [8];
      int ev_cyc [8];
      logic [1:0] exp_ack, elig;
      logic [15:0] first_rd;
      bit exp_busy, winner;

      ram_clr = 1'b1;
      reset = 1'b1;
      req = 2'b00; we = 2'b00;
      addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
      vecs[0] = '{1'b0, 1'b1, 8'h4c, 16'h2a12, 16'h0000};
      vecs[1] = '{1'b0, 1'b0, 8'h4c, 16'h0000, 16'h2a12};
      vecs[2] = '{1'b1, 1'b1, 8'hff, 16'hffff, 16'h0000};
      vecs[3] = '{1'b1, 1'b0, 8'hff, 16'h0000, 16'hffff};
      vecs[4] = '{1'b1, 1'b0, 8'h4c, 16'h0000, 16'h2a12};
      vecs[5] = '{1'b0, 1'b1, 8'h00, 16'h5a5a, 16'h2a12};
      vecs[6] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h5a5a};
      vecs[7] = '{1'b1, 1'b0, 8'h01, 16'h0000, 16'h0000};
      repeat (3) @(negedge clock50);
      ram_clr = 1'b0;
      reset_dut();

      check("rst_ack", ack, 0);
      check("rst_rdata0", rdata[0], 0);
      check("rst_rdata1", rdata[1], 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_din", ram_din, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_busy", busy, 0);

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_rdata", i), rdata[vecs[i].port], vecs[i].exp_rdata);
      end

      // simultaneous first requests: port 0 reads 0x10, port 1 writes 0xbeef there
      reset_dut();
      req = 2'b11; we = 2'b10; addr[0] = 8'h10; addr[1] = 8'h10; wdata[1] = 16'hbeef;
      t0 = -1; t1 = -1; first_rd = 'x;
      for (int c = 1; c <= 20 && (t0 < 0 || t1 < 0); c++) begin
         @(negedge clock50);
         if (ack[0]) begin t0 = c; first_rd = rdata[0]; req[0] = 1'b0; end
         if (ack[1]) begin t1 = c; req[1] = 1'b0; end
      end
      check("simul_ack0_cycle", t0, 3);
      check("simul_ack1_cycle", t1, 6);
      check("simul_old_value", first_rd, 16'h0000);
      @(negedge clock50);
      do_op(1'b0, 1'b0, 8'h10, 16'h0, "simul_reread");
      check("simul_reread_rdata", rdata[0], 16'hbeef);

      // sustained contention with registered requesters
      reset_dut();
      req = 2'b11; we = 2'b00; addr[0] = 8'h4c; addr[1] = 8'hff;
      drop = 2'b00; n_ev = 0; lowrun = 0; prev_busy = 1'b0; seen = 1'b0;
      for (int i = 0; i < 8; i++) begin ev_port[i] = 1'b0; ev_cyc[i] = 0; end
      for (int c = 0; c < 80 && n_ev < 8; c++) begin
         @(negedge clock50);
         if (ack != 2'b00) begin
            ev_port[n_ev] = ack[1]; ev_cyc[n_ev] = c; n_ev++; seen = 1'b1;
         end
         if (busy && !prev_busy && seen) check("contend_busy_gap", lowrun, 1);
         lowrun = busy ? 0 : lowrun + 1;
         prev_busy = busy;
         for (int p = 0; p < 2; p++) begin
            if (drop[p]) begin req[p] = 1'b0; drop[p] = 1'b0; end
            else req[p] = 1'b1;
            if (ack[p]) drop[p] = 1'b1;
         end
      end
      req = 2'b00;
      check("contend_count", n_ev, 8);
      for (int i = 0; i < 8; i++) check($sformatf("contend_order%0d", i), ev_port[i], i % 2);
      for (int i = 1; i < 8; i++) check($sformatf("contend_gap%0d", i), ev_cyc[i] - ev_cyc[i-1], 3);
      repeat (4) @(negedge clock50);

      // req0 still high during its ack cycle must not earn a second grant
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h4c; n = 0;
      do begin @(negedge clock50); n++; end while (!ack[0] && n < 20);
      check("hold_lat", n, 3);
      spurious = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock50);
         if (ack[0] || busy) spurious++;
         req[0] = 1'b0;
      end
      check("hold_no_regrant", spurious, 0);

      // reset during COMPLETE of a port 1 read
      reset_dut();
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'hff;
      @(negedge clock50);
      check("rst_rd_access_busy", busy, 1);
      @(negedge clock50);
      reset = 1'b1; req[1] = 1'b0;
      @(negedge clock50);
      check("rst_rd_no_ack1", ack[1], 0);
      check("rst_rd_rdata1", rdata[1], 0);
      check("rst_rd_busy", busy, 0);
      reset = 1'b0;
      do_op(1'b1, 1'b0, 8'hff, 16'h0, "rst_rd_next");
      check("rst_rd_next_rdata", rdata[1], 16'hffff);

      // reset during ACCESS of a write: the RAM still takes it
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'hff; wdata[0] = 16'h1234;
      @(negedge clock50);
      reset = 1'b1; req[0] = 1'b0;
      @(negedge clock50);
      check("rst_wr_no_ack0", ack[0], 0);
      reset = 1'b0;
      do_op(1'b0, 1'b0, 8'hff, 16'h0, "rst_wr_read");
      check("rst_wr_ram_value", rdata[0], 16'h1234);

      // inputs changing during ACCESS are ignored
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 16'h5555;
      @(negedge clock50);
      addr[0] = 8'h21; wdata[0] = 16'h6666;
      n = 1;
      do begin @(negedge clock50); n++; end while (!ack[0] && n < 20);
      check("chg_lat", n, 3);
      req[0] = 1'b0;
      @(negedge clock50);
      do_op(1'b0, 1'b0, 8'h20, 16'h0, "chg_read20");
      check("chg_rdata20", rdata[0], 16'h5555);
      do_op(1'b0, 1'b0, 8'h21, 16'h0, "chg_read21");
      check("chg_rdata21", rdata[0], 16'h0000);

      // randomized run against the transaction-timing model
      reset_dut();
      for (int i = 0; i < 256; i++) mem_ref[i] = ram[i];
      erd[0] = '0; erd[1] = '0; pv = 1'b0; last = 1'b1; pdone = 0;
      st[0] = 0; st[1] = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         exp_ack = 2'b00;
         if (pv && pdone == cyc) begin
            exp_ack[pport] = 1'b1;
            if (pread) erd[pport] = prd;
         end
         exp_busy = pv && cyc < pdone;
         check($sformatf("rand_cyc%0d", cyc), {ack, busy, rdata[0], rdata[1]},
               {exp_ack, exp_busy, erd[0], erd[1]});
         if (pv && pdone == cyc) pv = 1'b0;
         for (int p = 0; p < 2; p++) begin
            if (st[p] == 2) begin
               req[p] = 1'b0; st[p] = 0;
            end else if (st[p] == 1) begin
               if (ack[p]) st[p] = 2;
               else if ($urandom_range(3) == 0) begin
                  we[p] = 1'($urandom); wdata[p] = 16'($urandom);
                  addr[p] = ($urandom_range(1) == 0) ? 8'($urandom_range(3)) : 8'($urandom_range(255, 254));
               end
            end else if ($urandom_range(2) == 0) begin
               req[p] = 1'b1; st[p] = 1;
               we[p] = 1'($urandom); wdata[p] = 16'($urandom);
               addr[p] = ($urandom_range(1) == 0) ? 8'($urandom_range(3)) : 8'($urandom_range(255, 254));
            end
         end
         if (!pv) begin
            elig = req & ~exp_ack;
            if (elig != 2'b00) begin
               winner = (elig == 2'b11) ? !last : elig[1];
               last   = winner;
               pv     = 1'b1;
               pdone  = cyc + 3;
               pport  = winner;
               pread  = !we[winner];
               prd    = mem_ref[addr[winner]];
               if (we[winner]) mem_ref[addr[winner]] = wdata[winner];
            end
         end
         @(negedge clock50);
      end
      req = 2'b00;
      repeat (5) @(negedge clock50);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
